// File: rtl/fetch_unit.sv
// Instruction fetch: drives ROM word address, registers {instr, pc} into one slot handed to decode.
// Latency: redirect -> target on rom_addr_o next cycle -> valid slot the cycle after; 1 instr/cycle streaming.
// Backpressure: slot held (no ROM advance) while valid_o && !ready_i. Optional range check via `FETCH_FAULT_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned ROM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        halt_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        fault_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_HALT,
      S_FAULT
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic        load;
   logic        drain;
   logic        bad_fetch;

   assign rom_addr_o = {2'b00, pc[31:2]};
   assign load       = !valid_o || ready_i;
   assign drain      = valid_o && ready_i;

`ifdef FETCH_FAULT_EN
   localparam logic [29:0] DEPTH_W = 30'(ROM_DEPTH);
   logic fault_q;

   assign bad_fetch = (pc[1:0] != 2'b00) || (pc[31:2] >= DEPTH_W);
   assign fault_o   = fault_q;
`else
   assign bad_fetch = 1'b0;
   assign fault_o   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_BOOT;
         pc      <= RESET_PC;
         valid_o <= 1'b0;
         instr_o <= NOP;
         pc_o    <= 32'h0000_0000;
`ifdef FETCH_FAULT_EN
         fault_q <= 1'b0;
`endif
      end else if (state == S_BOOT) begin
         // one dead cycle after reset; redirect is ignored here
         state <= S_FETCH;
      end else if (redirect_i) begin
         pc      <= redirect_pc_i;
         valid_o <= 1'b0;
         state   <= S_FETCH;
`ifdef FETCH_FAULT_EN
         fault_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_FETCH: begin
               if (halt_i) begin
                  state <= S_HALT;
                  if (drain) valid_o <= 1'b0;
               end else if (bad_fetch) begin
                  state <= S_FAULT;
`ifdef FETCH_FAULT_EN
                  fault_q <= 1'b1;
`endif
                  if (drain) valid_o <= 1'b0;
               end else if (load) begin
                  instr_o <= rom_data_i;
                  pc_o    <= pc;
                  valid_o <= 1'b1;
                  pc      <= pc + 32'd4;
               end
            end
            default: begin
               // S_HALT / S_FAULT: no fetch, held slot drains normally
               if (drain) valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of expected accepted pcs plus directed timing checks.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        valid;
   logic        ready;
   logic        fault;

   logic [31:0] rom [256];
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   fetch_unit #(.RESET_PC(32'h0), .ROM_DEPTH(256)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rom_addr_o   (rom_addr),
      .rom_data_i   (rom_data),
      .redirect_i   (redirect),
      .redirect_pc_i(redirect_pc),
      .halt_i       (halt),
      .instr_o      (instr),
      .pc_o         (pc),
      .valid_o      (valid),
      .ready_i      (ready),
      .fault_o      (fault)
   );

   assign rom_data = (rom_addr < 32'd256) ? rom[rom_addr[7:0]] : 32'hDEAD_BEEF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Scores the slot being accepted at the coming edge, then advances one cycle.
   task automatic step();
      logic [31:0] e;
      if (valid === 1'b1 && ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("sb_extra", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("sb_pc", pc, e);
            check("sb_instr", instr, rom[e[9:2]]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
      step(); step();
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_instr", instr, 32'h0000_0013);
      check("rst_pc", pc, 32'd0);
      check("rst_fault", {31'b0, fault}, 32'd0);
      check("rst_addr", rom_addr, 32'd0);

      // Boot, stream, backpressure
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      rst_n = 1'b1;
      step();
      check("boot_dead", {31'b0, valid}, 32'd0);
      step();
      check("first_valid", {31'b0, valid}, 32'd1);
      check("first_pc", pc, 32'd0);
      step();
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_pc", pc, 32'h4);
         check("bp_instr", instr, rom[1]);
         check("bp_addr", rom_addr, 32'd2);
         check("bp_valid", {31'b0, valid}, 32'd1);
      end
      ready = 1'b1;
      step();
      check("bp_resume", pc, 32'h8);
      step();
      check("stream_d", pc, 32'hC);
      check("stream_d_instr", instr, rom[3]);

      // Redirect while slot held
      ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      check("redir_flush", {31'b0, valid}, 32'd0);
      check("redir_addr", rom_addr, 32'h10);
      step();
      check("redir_valid", {31'b0, valid}, 32'd1);
      check("redir_pc", pc, 32'h40);
      check("redir_instr", instr, rom[16]);
      exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
      ready = 1'b1;
      step(); step();

      // Halt mid-stream, then redirect out of halt
      halt = 1'b1;
      step();
      halt = 1'b0;
      check("halt_drop", {31'b0, valid}, 32'd0);
      step(); step();
      check("halt_idle", {31'b0, valid}, 32'd0);
      check("halt_addr", rom_addr, 32'h13);
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0;
      step();
      halt = 1'b0; redirect = 1'b0;
      check("unhalt_flush", {31'b0, valid}, 32'd0);
      step();
      check("unhalt_pc", pc, 32'h0);
      check("unhalt_valid", {31'b0, valid}, 32'd1);
      step(); step();
      ready = 1'b0; halt = 1'b1;
      step();
      halt = 1'b0;
      check("halt_hold", {31'b0, valid}, 32'd1);
      check("halt_hold_pc", pc, 32'h8);
      step();
      exp_q.push_back(32'h8);
      ready = 1'b1;
      step();
      check("halt_drain", {31'b0, valid}, 32'd0);

      // Out-of-range redirect
      ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
      step();
      redirect = 1'b0;
      check("oor_flush", {31'b0, valid}, 32'd0);
      step();
`ifdef FETCH_FAULT_EN
      check("fault_set", {31'b0, fault}, 32'd1);
      check("fault_noload", {31'b0, valid}, 32'd0);
      step(); step();
      check("fault_sticky", {31'b0, fault}, 32'd1);
      check("fault_idle", {31'b0, valid}, 32'd0);
`else
      check("nofault", {31'b0, fault}, 32'd0);
      check("oor_load", {31'b0, valid}, 32'd1);
      check("oor_pc", pc, 32'h400);
      step();
`endif
      redirect = 1'b1; redirect_pc = 32'h0;
      step();
      redirect = 1'b0;
      check("fault_clr", {31'b0, fault}, 32'd0);
      check("fault_clr_valid", {31'b0, valid}, 32'd0);
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      ready = 1'b1;
      step();
      check("resume_pc", pc, 32'h0);
      step(); step();

      // Reset mid-stream
      ready = 1'b0; rst_n = 1'b0;
      step();
      check("mrst_valid", {31'b0, valid}, 32'd0);
      check("mrst_addr", rom_addr, 32'd0);
      check("mrst_instr", instr, 32'h0000_0013);
      for (int i = 0; i < 40; i++) exp_q.push_back(32'(i * 4));
      rst_n = 1'b1; ready = 1'b1;
      step();
      check("mrst_dead", {31'b0, valid}, 32'd0);
      step();
      check("mrst_first", {31'b0, valid}, 32'd1);
      check("mrst_first_pc", pc, 32'h0);

      // Random backpressure stream
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 400) begin
         ready = 1'($urandom_range(0, 1));
         step();
         cyc++;
      end
      ready = 1'b0;
      check("stream_done", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
